axi4_burst_slave: RTL and testbench
===================================

AXI4_BURST_SLAVE -- requirements
Module: axi4_burst_slave

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, 32, data bus width (32 or 64).
- ADDR_WIDTH, 16, byte address width.
- MEMORY_DEPTH, 1024, memory words.
- ID_WIDTH, 4, transaction ID width.
REQ-002 Ports SHALL be:
- ACLK  in  1  clock.
- ARESET  in  1  reset.
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address.
- AWVALID in 1; AWREADY out 1.
- WDATA/WSTRB/WLAST/WVALID  in  DATA_WIDTH/DATA_WIDTH/8/1/1  write data.
- WREADY out 1.
- BID/BRESP/BVALID  out  ID_WIDTH/2/1  write response; BREADY in 1.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  as AW*  read address.
- ARVALID in 1; ARREADY out 1.
- RID/RDATA/RRESP/RLAST/RVALID  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; RREADY in 1.
REQ-003 The block SHALL use one clock, ACLK; reset ARESET SHALL be synchronous and active-high.

Function
REQ-004 The block SHALL contain an internal MEMORY_DEPTH x DATA_WIDTH array with one write port and one read port, and independent write and read FSMs.
REQ-005 Word index SHALL be addr >> log2(DATA_WIDTH/8).
REQ-006 Burst types SHALL be: FIXED (00) holds the address; INCR (01) adds 1<<SIZE; WRAP (10) adds 1<<SIZE and wraps within an aligned window of (LEN+1)<<SIZE bytes; 11 is reserved.
REQ-007 A burst SHALL be erroneous (SLVERR, 2'b10) if any of the following holds:
- SIZE > log2(DATA_WIDTH/8).
- BURST = 11.
- WRAP with LEN not in {1,3,7,15}, or start address not SIZE-aligned.
- INCR crossing 4 KB: (addr[11:0] + ((LEN+1)<<SIZE)) > 4096.
- Any beat word index >= MEMORY_DEPTH.
Size, burst-type and 4 KB checks SHALL be evaluated once on the captured address; the range check SHALL be evaluated per beat.
REQ-008 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
- W_IDLE: AWREADY=1; on AW handshake, capture AW* and go to W_DATA.
- W_DATA: WREADY=1 starting the cycle after the AW handshake.
- W_RESP: BVALID=1, BID = captured AWID; return to W_IDLE on BREADY.
REQ-009 Each W handshake SHALL write only byte lanes with WSTRB[i]=1, only when the burst is non-erroneous and the beat is in range; errored beats SHALL be accepted and discarded.
REQ-010 The slave SHALL accept exactly AWLEN+1 beats. WLAST asserted early, or deasserted on the final beat, SHALL set BRESP=SLVERR. After the final beat: WREADY=0, and BVALID=1 on the next cycle.
REQ-011 Read FSM SHALL have states R_IDLE, R_ADDR, R_DATA.
- R_IDLE: ARREADY=1; capture AR* on handshake.
- R_ADDR: issue the memory read.
- R_DATA: present the beat.
First RVALID SHALL occur 2 cycles after the AR handshake; each subsequent beat SHALL follow 2 cycles after the previous R handshake.
REQ-012 RID, RDATA, RRESP and RLAST SHALL be held stable while RVALID=1 and RREADY=0. RLAST=1 SHALL be asserted only on beat ARLEN. Errored beats SHALL return RDATA=0, RRESP=SLVERR.
REQ-013 The read and write channels SHALL run concurrently. When a read and a write target the same word in the same cycle, the read SHALL return the pre-write value.
REQ-014 Beat counters SHALL be 8 bits; address arithmetic SHALL be ADDR_WIDTH bits, truncating modulo 2^ADDR_WIDTH.
REQ-015 AWREADY SHALL be 0 outside W_IDLE and ARREADY SHALL be 0 outside R_IDLE (one outstanding transaction per direction).

Reset
REQ-016 While ARESET=1 at a rising ACLK edge, the block SHALL drive AWREADY=1, ARREADY=1, and all other outputs 0, and set both FSMs to idle.
REQ-017 Reset mid-burst SHALL abort the transaction with no response. Memory contents SHALL NOT be cleared.
REQ-018 Outputs SHALL take their reset values on the first ACLK edge with ARESET=1.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- INCR write, AWADDR=0x0010, LEN=3, SIZE=2, DATA=A0..A3, WSTRB=F -> BRESP=00, BID=AWID; INCR read of the same -> A0..A3, RLAST on beat 3 only.
- WRAP read, ARADDR=0x0038, LEN=3, SIZE=2 -> beats from addresses 0x38, 0x3C, 0x30, 0x34.
- Write with WSTRB=0x3, WDATA=0xDEADBEEF to a word holding 0x11223344 -> readback 0x1122BEEF.
- INCR write, AWADDR=0x0FF8, LEN=3, SIZE=2 -> BRESP=10, memory unchanged. Read at word index MEMORY_DEPTH -> RRESP=10, RDATA=0.
- WLAST asserted on beat 1 of a LEN=3 burst -> 4 beats accepted, BRESP=10. RREADY held low 5 cycles -> R outputs stable.
- ARESET pulsed mid read burst -> RVALID=0 and ARREADY=1 next edge; a subsequent read returns previously written data.

Source files
------------

// File: rtl/axi4_burst_slave.sv
// axi4_burst_slave: AXI4 burst slave over an internal word memory with
// independent write and read FSMs supporting FIXED, INCR and WRAP bursts.
module axi4_burst_slave #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int MEMORY_DEPTH = 1024,
   parameter int ID_WIDTH     = 4
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [ID_WIDTH-1:0]     AWID,
   input  logic [ADDR_WIDTH-1:0]   AWADDR,
   input  logic [7:0]              AWLEN,
   input  logic [2:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [DATA_WIDTH-1:0]   WDATA,
   input  logic [DATA_WIDTH/8-1:0] WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [ID_WIDTH-1:0]     BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   input  logic [ID_WIDTH-1:0]     ARID,
   input  logic [ADDR_WIDTH-1:0]   ARADDR,
   input  logic [7:0]              ARLEN,
   input  logic [2:0]              ARSIZE,
   input  logic [1:0]              ARBURST,
   input  logic                    ARVALID,
   output logic                    ARREADY,
   output logic [ID_WIDTH-1:0]     RID,
   output logic [DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]              RRESP,
   output logic                    RLAST,
   output logic                    RVALID,
   input  logic                    RREADY
);
   localparam int NB = DATA_WIDTH / 8;
   localparam int LB = $clog2(NB);
   localparam int IW = $clog2(MEMORY_DEPTH);
   typedef logic [ADDR_WIDTH-1:0] addr_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;

   logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];

   function automatic logic bad(input addr_t a, input logic [7:0] len, input logic [2:0] size,
                                input logic [1:0] burst);
      return (32'(size) > LB) || (burst == 2'b11)
         || (burst == 2'b10 && (!(len inside {8'd1, 8'd3, 8'd7, 8'd15})
            || (32'(a) & ((32'd1 << size) - 32'd1)) != 32'd0))
         || (burst == 2'b01 && (32'(a[11:0]) + ((32'(len) + 32'd1) << size)) > 32'd4096);
   endfunction

   // WRAP keeps the bits above the window and increments only within it
   function automatic addr_t nxt(input addr_t a, input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
      addr_t inc, m;
      inc = addr_t'(1) << size;
      m = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
      return burst == 2'b00 ? a : burst == 2'b10 ? ((a & ~m) | ((a + inc) & m)) : a + inc;
   endfunction

   function automatic logic in_rng(input addr_t a);
      return (32'(a) >> LB) < 32'(MEMORY_DEPTH);
   endfunction

   function automatic logic [IW-1:0] widx(input addr_t a);
      return IW'(a >> LB);
   endfunction

   w_state_e              wst_q;
   logic [ID_WIDTH-1:0]   wid_q;
   addr_t                 waddr_q, waddr_d;
   logic [7:0]            wlen_q, wcnt_q;
   logic [2:0]            wsize_q;
   logic [1:0]            wburst_q, bresp_q;
   logic                  wbad_q, werr_q, awready_q, wready_q, bvalid_q;
   logic                  wok_d, wfin_d, wberr_d;

   assign waddr_d = nxt(waddr_q, wlen_q, wsize_q, wburst_q);
   assign wok_d   = !wbad_q && in_rng(waddr_q);
   assign wfin_d  = wcnt_q == wlen_q;
   assign wberr_d = werr_q || !wok_d || (WLAST != wfin_d);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wst_q     <= W_IDLE;
         awready_q <= 1'b1;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
         wid_q     <= '0;
         werr_q    <= 1'b0;
         wcnt_q    <= 8'd0;
      end else begin
         case (wst_q)
            W_IDLE: if (AWVALID) begin
               wid_q     <= AWID;
               waddr_q   <= AWADDR;
               wlen_q    <= AWLEN;
               wsize_q   <= AWSIZE;
               wburst_q  <= AWBURST;
               wbad_q    <= bad(AWADDR, AWLEN, AWSIZE, AWBURST);
               werr_q    <= 1'b0;
               wcnt_q    <= 8'd0;
               awready_q <= 1'b0;
               wready_q  <= 1'b1;
               wst_q     <= W_DATA;
            end
            W_DATA: if (WVALID) begin
               werr_q <= wberr_d;
               if (wfin_d) begin
                  wready_q <= 1'b0;
                  bvalid_q <= 1'b1;
                  bresp_q  <= wberr_d ? 2'b10 : 2'b00;
                  wst_q    <= W_RESP;
               end else begin
                  wcnt_q  <= wcnt_q + 8'd1;
                  waddr_q <= waddr_d;
               end
            end
            W_RESP: if (BREADY) begin
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
               wst_q     <= W_IDLE;
            end
            default: wst_q <= W_IDLE;
         endcase
      end
   end

   // memory is deliberately not reset; only the lanes enabled by WSTRB change
   always_ff @(posedge ACLK) begin
      if (!ARESET && wst_q == W_DATA && WVALID && wok_d)
         for (int i = 0; i < NB; i++)
            if (WSTRB[i]) mem_q[widx(waddr_q)][8*i +: 8] <= WDATA[8*i +: 8];
   end

   r_state_e              rst_q;
   logic [ID_WIDTH-1:0]   rid_q;
   addr_t                 raddr_q, raddr_d;
   logic [7:0]            rlen_q, rcnt_q;
   logic [2:0]            rsize_q;
   logic [1:0]            rburst_q, rresp_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rbad_q, arready_q, rvalid_q, rlast_q, rok_d;

   assign raddr_d = nxt(raddr_q, rlen_q, rsize_q, rburst_q);
   assign rok_d   = !rbad_q && in_rng(raddr_q);

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         rst_q     <= R_IDLE;
         arready_q <= 1'b1;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rresp_q   <= 2'b00;
         rdata_q   <= '0;
         rid_q     <= '0;
         rcnt_q    <= 8'd0;
      end else begin
         case (rst_q)
            R_IDLE: if (ARVALID) begin
               rid_q     <= ARID;
               raddr_q   <= ARADDR;
               rlen_q    <= ARLEN;
               rsize_q   <= ARSIZE;
               rburst_q  <= ARBURST;
               rbad_q    <= bad(ARADDR, ARLEN, ARSIZE, ARBURST);
               rcnt_q    <= 8'd0;
               arready_q <= 1'b0;
               rst_q     <= R_ADDR;
            end
            R_ADDR: begin
               rvalid_q <= 1'b1;
               rlast_q  <= rcnt_q == rlen_q;
               rresp_q  <= rok_d ? 2'b00 : 2'b10;
               rdata_q  <= rok_d ? mem_q[widx(raddr_q)] : '0;
               rst_q    <= R_DATA;
            end
            R_DATA: if (RREADY) begin
               rvalid_q <= 1'b0;
               if (rlast_q) begin
                  arready_q <= 1'b1;
                  rst_q     <= R_IDLE;
               end else begin
                  rcnt_q  <= rcnt_q + 8'd1;
                  raddr_q <= raddr_d;
                  rst_q   <= R_ADDR;
               end
            end
            default: rst_q <= R_IDLE;
         endcase
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign BID     = wid_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RLAST   = rlast_q;
   assign RRESP   = rresp_q;
   assign RDATA   = rdata_q;
   assign RID     = rid_q;
endmodule

// File: tb/tb_axi4_burst_slave.sv
// tb_axi4_burst_slave: directed and randomized bursts checked against a
// byte-address-level reference model of the slave memory.
module tb_axi4_burst_slave;
   logic        ACLK, ARESET;
   logic [3:0]  AWID, ARID, BID, RID;
   logic [15:0] AWADDR, ARADDR;
   logic [7:0]  AWLEN, ARLEN;
   logic [2:0]  AWSIZE, ARSIZE;
   logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
   logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
   logic [31:0] WDATA, RDATA;
   logic [3:0]  WSTRB;

   axi4_burst_slave dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
      .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
      .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int          tests = 0, fails = 0;
   logic [31:0] mdl [1024];
   logic [31:0] wd [256];
   logic [3:0]  ws [256];
   logic [31:0] last_rd [256];
   logic [1:0]  last_bresp, last_rresp;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int mdl_addr(int a, int len, int sz, int bt, int i);
      int by = 1 << sz;
      int win = (len + 1) * by;
      int base;
      if (bt == 0) return a;
      if (bt == 2) begin
         base = a - a % win;
         return base + (a - base + i * by) % win;
      end
      return (a + i * by) % 65536;
   endfunction

   function automatic bit mdl_bad(int a, int len, int sz, int bt);
      int by = 1 << sz;
      if (sz > 2 || bt == 3) return 1;
      if (bt == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1;
      if (bt == 2 && a % by != 0) return 1;
      if (bt == 1 && (a % 4096 + (len + 1) * by) > 4096) return 1;
      return 0;
   endfunction

   task automatic do_write(input logic [3:0] id, input int a, input int len, input int sz,
                           input int bt, input int lastpos);
      int n, ad;
      bit bad, err;
      AWID = id; AWADDR = 16'(a); AWLEN = 8'(len); AWSIZE = 3'(sz); AWBURST = 2'(bt);
      AWVALID = 1'b1;
      n = 0;
      while (!AWREADY && n < 20) begin @(posedge ACLK); #1; n++; end
      check("awready", AWREADY, 1);
      @(posedge ACLK); #1;
      AWVALID = 1'b0;
      check("awready_busy", AWREADY, 0);
      for (int b = 0; b <= len; b++) begin
         WVALID = 1'b1; WDATA = wd[b]; WSTRB = ws[b]; WLAST = (b == lastpos);
         n = 0;
         while (!WREADY && n < 20) begin @(posedge ACLK); #1; n++; end
         check("wready", WREADY, 1);
         @(posedge ACLK); #1;
      end
      WVALID = 1'b0; WLAST = 1'b0;
      bad = mdl_bad(a, len, sz, bt);
      err = bad || (lastpos != len);
      for (int i = 0; i <= len; i++) begin
         ad = mdl_addr(a, len, sz, bt, i);
         if (!bad && ad / 4 >= 1024) err = 1;
         if (!bad && ad / 4 < 1024)
            for (int k = 0; k < 4; k++) if (ws[i][k]) mdl[ad / 4][8*k +: 8] = wd[i][8*k +: 8];
      end
      check("wready_end", WREADY, 0);
      check("bvalid", BVALID, 1);
      check("bid", BID, id);
      check("bresp", BRESP, err ? 2'b10 : 2'b00);
      last_bresp = BRESP;
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      check("bvalid_end", BVALID, 0);
      check("awready_idle", AWREADY, 1);
   endtask

   task automatic do_read(input logic [3:0] id, input int a, input int len, input int sz,
                          input int bt, input int stall);
      int n, ad;
      bit bad, e;
      logic [31:0] ed;
      ARID = id; ARADDR = 16'(a); ARLEN = 8'(len); ARSIZE = 3'(sz); ARBURST = 2'(bt);
      ARVALID = 1'b1;
      n = 0;
      while (!ARREADY && n < 20) begin @(posedge ACLK); #1; n++; end
      check("arready", ARREADY, 1);
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      check("arready_busy", ARREADY, 0);
      bad = mdl_bad(a, len, sz, bt);
      for (int i = 0; i <= len; i++) begin
         ad = mdl_addr(a, len, sz, bt, i);
         e = bad || ad / 4 >= 1024;
         ed = e ? 32'h0 : mdl[ad / 4];
         check("rvalid_gap", RVALID, 0);
         @(posedge ACLK); #1;
         last_rd[i] = RDATA;
         if (i == 0) last_rresp = RRESP;
         for (int s = 0; s <= stall; s++) begin
            if (s > 0) begin @(posedge ACLK); #1; end
            check("rvalid", RVALID, 1);
            check("rid", RID, id);
            check("rdata", RDATA, ed);
            check("rresp", RRESP, e ? 2'b10 : 2'b00);
            check("rlast", RLAST, i == len);
         end
         RREADY = 1'b1;
         @(posedge ACLK); #1;
         RREADY = 1'b0;
      end
      check("arready_idle", ARREADY, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, len, sz, bt;
      logic [31:0] old0, old1;
      ARESET = 1'b1;
      AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
      ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
      RREADY = 1'b0;
      @(posedge ACLK); #1;
      check("rst_awready", AWREADY, 1);
      check("rst_arready", ARREADY, 1);
      check("rst_wready", WREADY, 0);
      check("rst_bvalid", BVALID, 0);
      check("rst_rvalid", RVALID, 0);
      check("rst_outs", {BID, BRESP, RID, RDATA, RRESP, RLAST}, 0);
      @(posedge ACLK); #1;
      ARESET = 1'b0;

      for (int p = 0; p < 4; p++) begin
         for (int b = 0; b < 256; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
         do_write(0, p * 1024, 255, 2, 1, 255);
      end

      for (int b = 0; b < 4; b++) begin wd[b] = 32'hA0 + b; ws[b] = 4'hF; end
      do_write(5, 'h10, 3, 2, 1, 3);
      check("incr_bresp", last_bresp, 2'b00);
      do_read(5, 'h10, 3, 2, 1, 0);
      for (int b = 0; b < 4; b++) check("incr_rd", last_rd[b], 32'hA0 + b);

      do_read(2, 'h38, 3, 2, 2, 0);
      check("wrap_b0", last_rd[0], mdl[14]);
      check("wrap_b1", last_rd[1], mdl[15]);
      check("wrap_b2", last_rd[2], mdl[12]);
      check("wrap_b3", last_rd[3], mdl[13]);

      wd[0] = 32'h11223344; ws[0] = 4'hF;
      do_write(1, 'h100, 0, 2, 1, 0);
      wd[0] = 32'hDEADBEEF; ws[0] = 4'h3;
      do_write(1, 'h100, 0, 2, 1, 0);
      do_read(1, 'h100, 0, 2, 1, 0);
      check("strobe_rd", last_rd[0], 32'h1122BEEF);

      old0 = mdl[1022]; old1 = mdl[1023];
      for (int b = 0; b < 4; b++) begin wd[b] = 32'hBAD0 + b; ws[b] = 4'hF; end
      do_write(6, 'hFF8, 3, 2, 1, 3);
      check("4k_bresp", last_bresp, 2'b10);
      do_read(6, 'hFF8, 1, 2, 1, 0);
      check("4k_keep0", last_rd[0], old0);
      check("4k_keep1", last_rd[1], old1);
      do_read(7, 'h1000, 0, 2, 1, 0);
      check("oob_rresp", last_rresp, 2'b10);
      check("oob_rdata", last_rd[0], 0);

      for (int b = 0; b < 4; b++) begin wd[b] = $urandom; ws[b] = 4'hF; end
      do_write(3, 'h200, 3, 2, 1, 1);
      check("wlast_bresp", last_bresp, 2'b10);
      do_read(3, 'h10, 3, 2, 1, 5);

      ARID = 4'd9; ARADDR = 16'h10; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'd1;
      ARVALID = 1'b1;
      @(posedge ACLK); #1;
      ARVALID = 1'b0;
      @(posedge ACLK); #1;
      check("abort_rvalid_pre", RVALID, 1);
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      check("abort_rvalid", RVALID, 0);
      check("abort_arready", ARREADY, 1);
      ARESET = 1'b0;
      do_read(9, 'h10, 3, 2, 1, 0);
      check("abort_rd", last_rd[0], 32'hA0);

      for (int b = 0; b < 8; b++) begin wd[b] = $urandom; ws[b] = 4'(b + 9); end
      fork
         do_write(10, 'h400, 7, 2, 1, 7);
         do_read(11, 'h600, 7, 2, 1, 1);
      join
      do_read(10, 'h400, 7, 2, 1, 0);

      for (int t = 0; t < 60; t++) begin
         sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         bt = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
         case ($urandom_range(0, 5))
            0: len = 0;
            1: len = 1;
            2: len = 3;
            3: len = 7;
            4: len = 15;
            default: len = $urandom_range(0, 30);
         endcase
         a = $urandom_range(0, 4500);
         if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
         if ($urandom_range(0, 1) == 0) begin
            for (int b = 0; b <= len; b++) begin wd[b] = $urandom; ws[b] = 4'($urandom); end
            do_write(4'($urandom), a, len, sz, bt, len);
         end else
            do_read(4'($urandom), a, len, sz, bt, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
